// File: rtl/pixel_ram_arbiter_if.sv
// ============================================================================
// Module   : pixel_ram_arbiter_if
// Purpose  : Display read, pixel write, clear control and RAM bus signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_ram_arbiter_if;
  logic        rdn;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [11:0] pixel_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;
  logic        clear_start;
  logic [11:0] clear_color;
  logic        busy;
  logic        clear_done;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  modport slave (
    input  rdn, row_addr, col_addr, wr_valid, wr_row, wr_col, wr_data,
           clear_start, clear_color, ram_rdata,
    output pixel_data, wr_ready, busy, clear_done, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output rdn, row_addr, col_addr, wr_valid, wr_row, wr_col, wr_data,
           clear_start, clear_color, ram_rdata,
    input  pixel_data, wr_ready, busy, clear_done, ram_addr, ram_we, ram_wdata
  );
endinterface

`default_nettype wire

// File: rtl/pixel_ram_arbiter.sv
// ============================================================================
// Module   : pixel_ram_arbiter
// Purpose  : Shares the single-port pixel RAM between display reads, a
//            buffered pixel write port and a full-frame clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_ram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input wire                 vga_clk,
  input wire                 clrn,
  pixel_ram_arbiter_if.slave bus
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam int               ENT_W    = 31;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [9:0]       COL_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0]       ROW_LAST = 9'(V_ACTIVE - 1);
  localparam logic [10:0]      COL_LIM  = 11'(H_ACTIVE);
  localparam logic [9:0]       ROW_LIM  = 10'(V_ACTIVE);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [8:0]         clr_row_q, clr_row_d;
  logic [9:0]         clr_col_q, clr_col_d;
  logic [11:0]        clr_color_q, clr_color_d;
  logic [11:0]        pixel_q, pixel_d;
  logic               rd_pend_q, rd_pend_d;
  logic               done_q, done_d;
  logic [18:0]        last_addr_q, last_addr_d;

  logic               rd_grant;
  logic               clr_grant;
  logic               pop;
  logic               push;
  logic               wr_ready;
  logic               in_range;
  logic [ENT_W-1:0]   head;
  logic [18:0]        ram_addr;
  logic               ram_we;
  logic [11:0]        ram_wdata;

  // Reads are gated by clrn so every RAM-side output reads zero during reset.
  assign rd_grant  = clrn && !bus.rdn;
  assign clr_grant = !rd_grant && (state_q == ST_CLEAR);
  assign pop       = !rd_grant && (state_q == ST_IDLE) && (count_q != '0);
  assign wr_ready  = (state_q == ST_IDLE) && (count_q != FULL_CNT);
  assign in_range  = ({1'b0, bus.wr_row} < ROW_LIM) && ({1'b0, bus.wr_col} < COL_LIM);
  assign push      = bus.wr_valid && wr_ready && in_range;
  assign head      = fifo_q[rptr_q];

  always_comb begin
    ram_addr  = last_addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (rd_grant) begin
      ram_addr = {bus.row_addr, bus.col_addr};
    end else if (clr_grant) begin
      ram_addr  = {clr_row_q, clr_col_q};
      ram_we    = 1'b1;
      ram_wdata = clr_color_q;
    end else if (pop) begin
      ram_addr  = head[30:12];
      ram_we    = 1'b1;
      ram_wdata = head[11:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    clr_row_d   = clr_row_q;
    clr_col_d   = clr_col_q;
    clr_color_d = clr_color_q;
    pixel_d     = pixel_q;
    rd_pend_d   = rd_grant;
    done_d      = 1'b0;
    last_addr_d = ram_addr;

    if (rd_pend_q) pixel_d = bus.ram_rdata;

    if (push) begin
      fifo_d[wptr_q] = {bus.wr_row, bus.wr_col, bus.wr_data};
      wptr_d         = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        // Clear start discards everything buffered, including a same-cycle push.
        if (bus.clear_start) begin
          state_d     = ST_CLEAR;
          clr_color_d = bus.clear_color;
          clr_row_d   = '0;
          clr_col_d   = '0;
          wptr_d      = '0;
          rptr_d      = '0;
          count_d     = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_grant) begin
          if (clr_col_q == COL_LAST) begin
            clr_col_d = '0;
            if (clr_row_q == ROW_LAST) begin
              clr_row_d = '0;
              state_d   = ST_IDLE;
              done_d    = 1'b1;
            end else begin
              clr_row_d = clr_row_q + 9'd1;
            end
          end else begin
            clr_col_d = clr_col_q + 10'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      clr_row_q   <= '0;
      clr_col_q   <= '0;
      clr_color_q <= '0;
      pixel_q     <= '0;
      rd_pend_q   <= 1'b0;
      done_q      <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      clr_row_q   <= clr_row_d;
      clr_col_q   <= clr_col_d;
      clr_color_q <= clr_color_d;
      pixel_q     <= pixel_d;
      rd_pend_q   <= rd_pend_d;
      done_q      <= done_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign bus.pixel_data = pixel_q;
  assign bus.wr_ready   = wr_ready;
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.clear_done = done_q;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_we     = ram_we;
  assign bus.ram_wdata  = ram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_pixel_ram_arbiter.sv
// ============================================================================
// Module   : tb_pixel_ram_arbiter
// Purpose  : Scoreboard bench for pixel_ram_arbiter on a reduced 16x8 frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_ram_arbiter;
  localparam int DEPTH = 4;
  localparam int H     = 16;
  localparam int V     = 8;
  localparam int NPIX  = H * V;
  localparam logic [18:0] PRE_ADDR = {9'd5, 10'd7};

  typedef struct packed {
    logic [18:0] addr;
    logic [11:0] data;
    logic        last;
  } wr_t;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  pixel_ram_arbiter_if bus();

  pixel_ram_arbiter #(.FIFO_DEPTH(DEPTH), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .vga_clk (clk),
    .clrn    (clrn),
    .bus     (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   tmo_cnt  = 0;
  int   tmo_seen = 0;
  int   clr_issued   = 0;
  int   clr_finished = 0;
  wr_t  exp_wr[$];
  logic [11:0] ram   [0:(1<<19)-1];
  logic [11:0] frame [0:(1<<19)-1];

  // Synchronous-read RAM owned by the bench.
  initial begin
    logic [11:0] rd;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) ram[{9'(r), 10'(c)}] = 12'h000;
    ram[PRE_ADDR] = 12'hABC;
    bus.ram_rdata = 12'h000;
    forever begin
      @(posedge clk);
      rd = ram[bus.ram_addr];
      if (bus.ram_we) ram[bus.ram_addr] = bus.ram_wdata;
      bus.ram_rdata <= rd;
    end
  end

  // Expected RAM writes, in order, produced from accepted stimulus.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      exp_wr.delete();
      clr_issued = 0;
    end else if (bus.clear_start && (clr_issued == clr_finished)) begin
      exp_wr.delete();
      for (int r = 0; r < V; r++)
        for (int c = 0; c < H; c++)
          exp_wr.push_back('{addr: {9'(r), 10'(c)}, data: bus.clear_color,
                             last: (r == V - 1) && (c == H - 1)});
      clr_issued++;
    end else if (bus.wr_valid && bus.wr_ready && (bus.wr_row < V) && (bus.wr_col < H)) begin
      exp_wr.push_back('{addr: {bus.wr_row, bus.wr_col}, data: bus.wr_data, last: 1'b0});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares every cycle against the reference model.
  initial begin
    logic [11:0] last_pix, p1_val, p2_val;
    logic        p1_vld, p2_vld, done_exp, busy_exp;
    logic [18:0] last_addr, a;
    wr_t         e;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) frame[{9'(r), 10'(c)}] = 12'h000;
    frame[PRE_ADDR] = 12'hABC;
    last_pix = '0; p1_vld = 0; p2_vld = 0; p1_val = '0; p2_val = '0;
    done_exp = 0; last_addr = '0;
    forever begin
      @(negedge clk);
      if (tmo_cnt != tmo_seen) begin
        checks++;
        failures++;
        $display("FAIL wait_timeout: %0d waits expired, required 0", tmo_cnt - tmo_seen);
        tmo_seen = tmo_cnt;
      end
      if (!clrn) begin
        chk("rst_pixel_data", bus.pixel_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_clear_done", bus.clear_done, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);
        last_pix = '0; p1_vld = 0; p2_vld = 0;
        done_exp = 0; last_addr = '0; clr_finished = 0;
      end else begin
        busy_exp = (clr_issued != clr_finished);
        if (p2_vld) last_pix = p2_val;
        chk("pixel_data", bus.pixel_data, last_pix);
        p2_vld = p1_vld; p2_val = p1_val; p1_vld = 0;
        chk("busy", bus.busy, busy_exp);
        chk("clear_done", bus.clear_done, done_exp);
        done_exp = 0;
        chk("wr_ready", bus.wr_ready, !busy_exp && (exp_wr.size() < DEPTH));
        chk("ram_we", bus.ram_we, bus.rdn && (exp_wr.size() > 0));
        if (!bus.rdn) begin
          a = {bus.row_addr, bus.col_addr};
          chk("read_addr", bus.ram_addr, a);
          p1_vld = 1; p1_val = frame[a];
          last_addr = a;
        end else if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("write_addr", bus.ram_addr, e.addr);
          chk("write_data", bus.ram_wdata, e.data);
          frame[e.addr] = e.data;
          last_addr = e.addr;
          if (e.last) begin
            done_exp = 1;
            clr_finished++;
          end
        end else begin
          chk("idle_addr", bus.ram_addr, last_addr);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [8:0] r, input logic [9:0] c, input logic [11:0] d,
                       input int budget, output bit acc);
    bus.wr_valid = 1; bus.wr_row = r; bus.wr_col = c; bus.wr_data = d;
    acc = 0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (bus.wr_ready) acc = 1;
      cyc();
    end
    bus.wr_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.clear_done) seen = 1;
    end
    if (!seen) tmo_cnt++;
    cyc();
  endtask

  task automatic read_px(input int r, input int c);
    bus.rdn = 0; bus.row_addr = 9'(r); bus.col_addr = 10'(c);
    cyc();
    bus.rdn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    clrn = 0; bus.rdn = 1; bus.row_addr = '0; bus.col_addr = '0;
    bus.wr_valid = 0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.clear_start = 0; bus.clear_color = '0;
    repeat (3) cyc();
    clrn = 1;

    // Preloaded pixel read right after reset
    read_px(5, 7);
    repeat (3) cyc();

    // Reads starve writes: four buffered, fifth back-pressured
    bus.rdn = 0; bus.row_addr = 9'd2; bus.col_addr = 10'd3;
    for (int i = 0; i < 5; i++) begin
      offer(9'(i), 10'(i + 1), 12'(12'h100 + i), 6, acc);
      if ((i < 4) != acc) tmo_cnt++;
    end
    bus.rdn = 1;
    repeat (6) cyc();

    // Simultaneous push and pop at count 2, then out-of-range writes
    bus.rdn = 0;
    offer(9'd3, 10'd3, 12'h201, 4, acc); if (!acc) tmo_cnt++;
    offer(9'd3, 10'd4, 12'h202, 4, acc); if (!acc) tmo_cnt++;
    bus.rdn = 1;
    for (int i = 0; i < 4; i++) begin
      offer(9'd4, 10'(i), 12'(12'h300 + i), 4, acc);
      if (!acc) tmo_cnt++;
    end
    offer(9'(V), 10'd0, 12'hBAD, 4, acc); if (!acc) tmo_cnt++;
    offer(9'd0, 10'(H), 12'hBAD, 4, acc); if (!acc) tmo_cnt++;
    repeat (6) cyc();

    // Random mix of reads and writes, some out of range
    for (int i = 0; i < 400; i++) begin
      bus.rdn      = 1'($urandom_range(0, 1));
      bus.row_addr = 9'($urandom_range(0, V - 1));
      bus.col_addr = 10'($urandom_range(0, H - 1));
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_row   = 9'($urandom_range(0, V));
      bus.wr_col   = 10'($urandom_range(0, H));
      bus.wr_data  = 12'($urandom);
      cyc();
    end
    bus.wr_valid = 0; bus.rdn = 1;
    repeat (8) cyc();

    // Full clear with no reads, then read back the whole frame
    bus.clear_start = 1; bus.clear_color = 12'h0F0;
    cyc();
    bus.clear_start = 0;
    wait_done(NPIX + 10);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) read_px(r, c);
    repeat (4) cyc();

    // Clear start with a same-cycle write, then reads every other cycle
    bus.wr_valid = 1; bus.wr_row = 9'd1; bus.wr_col = 10'd1; bus.wr_data = 12'hFFF;
    bus.clear_start = 1; bus.clear_color = 12'h00F;
    cyc();
    bus.clear_start = 0; bus.wr_valid = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 2 * NPIX + 10 && !seen; i++) begin
        bus.rdn      = (i % 2 == 1);
        bus.row_addr = 9'($urandom_range(0, V - 1));
        bus.col_addr = 10'($urandom_range(0, H - 1));
        @(negedge clk);
        if (bus.clear_done) seen = 1;
        cyc();
      end
      if (!seen) tmo_cnt++;
    end
    bus.rdn = 1;
    read_px(1, 1);
    repeat (3) cyc();

    // Reset in the middle of a clear, then a fresh clear
    bus.clear_start = 1; bus.clear_color = 12'h123;
    cyc();
    bus.clear_start = 0;
    repeat (20) cyc();
    clrn = 0; bus.rdn = 0; bus.row_addr = 9'd5; bus.col_addr = 10'd7;
    repeat (3) cyc();
    bus.rdn = 1; clrn = 1;
    cyc();
    bus.clear_start = 1; bus.clear_color = 12'h456;
    cyc();
    bus.clear_start = 0;
    wait_done(NPIX + 10);
    for (int r = 0; r < V; r++) read_px(r, r);
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
